multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/alu_func_decode.sv | 27 ++
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit.
// Holds the state codes, ALU control codes, ALU operand / PC source
// select codes, and the opcode / funct constants decoded by the FSM.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADDR = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_RWB     = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_ADDIEX  = 4'd10,
        ST_ADDIWB  = 4'd11,
        ST_ERR     = 4'd15
    } state_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/alu_func_decode.sv
// R-type funct decoder.
//   func_i     : funct field of the instruction
//   alu_cntl_o : ALU operation for that funct (0 when unsupported)
//   valid_o    : funct is one of the supported R-type operations
module alu_func_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] func_i,
    output logic [3:0] alu_cntl_o,
    output logic       valid_o
);

    always_comb begin
        alu_cntl_o = ALU_AND;
        valid_o    = 1'b1;
        case (func_i)
            FN_ADD:  alu_cntl_o = ALU_ADD;
            FN_SUB:  alu_cntl_o = ALU_SUB;
            FN_AND:  alu_cntl_o = ALU_AND;
            FN_OR:   alu_cntl_o = ALU_OR;
            FN_NOR:  alu_cntl_o = ALU_NOR;
            FN_SLT:  alu_cntl_o = ALU_SLT;
            default: valid_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit (R-type, lw, sw, beq, bne, addi, j).
// Inputs : clock, Reset (sync, active low), Op, Func, Z, mem_ready.
// Outputs: datapath enables/selects (PCEn, IRWrite, IorD, MemRead,
//          MemWrite, RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB,
//          ALUCntl, PCSource), Halt on illegal instruction, the current
//          State code and InstCount, the number of retired instructions.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        Reset,
    input  logic [5:0]  Op,
    input  logic [5:0]  Func,
    input  logic        Z,
    input  logic        mem_ready,
    output logic        PCEn,
    output logic        IRWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUCntl,
    output logic [1:0]  PCSource,
    output logic        Halt,
    output logic [3:0]  State,
    output logic [31:0] InstCount
);

    state_e      state_q, state_d;
    logic [31:0] inst_count_q, inst_count_d;
    logic [3:0]  func_cntl;
    logic        func_valid;

    alu_func_decode u_func_dec (
        .func_i     (Func),
        .alu_cntl_o (func_cntl),
        .valid_o    (func_valid)
    );

    always_ff @(posedge clock) begin
        if (!Reset) begin
            state_q      <= ST_FETCH;
            inst_count_q <= '0;
        end else begin
            state_q      <= state_d;
            inst_count_q <= inst_count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        PCEn     = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_RT;
        ALUCntl  = ALU_AND;
        PCSource = PCSRC_ALU;
        Halt     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUCntl = ALU_ADD;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCEn    = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch target is computed here so BRANCH can use ALUOut.
                ALUSrcB = SRCB_IMM_SL2;
                ALUCntl = ALU_ADD;
                case (Op)
                    OP_RTYPE:      state_d = ST_EXEC;
                    OP_LW, OP_SW:  state_d = ST_MEMADDR;
                    OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                    OP_ADDI:       state_d = ST_ADDIEX;
                    OP_J:          state_d = ST_JUMP;
                    default:       state_d = ST_ERR;
                endcase
            end
            ST_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUCntl = ALU_ADD;
                state_d = (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUCntl = func_cntl;
                state_d = func_valid ? ST_RWB : ST_ERR;
            end
            ST_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUCntl  = ALU_SUB;
                PCSource = PCSRC_ALUOUT;
                PCEn     = (Op == OP_BNE) ? ~Z : Z;
                state_d  = ST_FETCH;
            end
            ST_JUMP: begin
                PCSource = PCSRC_JUMP;
                PCEn     = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUCntl = ALU_ADD;
                state_d = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_ERR: begin
                Halt    = 1'b1;
                state_d = ST_ERR;
            end
            default: state_d = ST_ERR;  // unused codes 12-14
        endcase

        // Strobes are held off combinationally so nothing fires in the
        // cycles before the synchronous reset has taken the FSM to FETCH.
        if (!Reset) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    // Every path back into FETCH from another state is an instruction
    // completing; FETCH->FETCH is a fetch wait and ERR never leaves.
    always_comb begin
        inst_count_d = inst_count_q;
        if (state_d == ST_FETCH && state_q != ST_FETCH && state_q != ST_ERR)
            inst_count_d = inst_count_q + 32'd1;
    end

    assign State     = state_q;
    assign InstCount = inst_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        Reset;
    logic [5:0]  Op, Func;
    logic        Z, mem_ready;
    logic        PCEn, IRWrite, IorD, MemRead, MemWrite, RegWrite;
    logic        RegDst, MemToReg, ALUSrcA, Halt;
    logic [1:0]  ALUSrcB, PCSource;
    logic [3:0]  ALUCntl, State;
    logic [31:0] InstCount;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] cnt_model = 32'd0;

    multicycle_control dut (
        .clock(clock), .Reset(Reset), .Op(Op), .Func(Func), .Z(Z),
        .mem_ready(mem_ready), .PCEn(PCEn), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUCntl(ALUCntl), .PCSource(PCSource),
        .Halt(Halt), .State(State), .InstCount(InstCount)
    );

    always #5 clock = ~clock;

    // ALU operation required for each supported funct code.
    function automatic logic [4:0] func_alu(input logic [5:0] f);
        // {legal, ALUCntl}
        case (f)
            6'h20:   return {1'b1, 4'b0010};
            6'h22:   return {1'b1, 4'b0110};
            6'h24:   return {1'b1, 4'b0000};
            6'h25:   return {1'b1, 4'b0001};
            6'h27:   return {1'b1, 4'b1100};
            6'h2A:   return {1'b1, 4'b0111};
            default: return 5'b0;
        endcase
    endfunction

    // Hold reset two cycles, release it and leave the FSM idling in FETCH.
    task automatic apply_reset();
        @(negedge clock);
        Reset = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        Reset = 1'b1;
        cnt_model = 32'd0;
    endtask

    // Executes one instruction: builds the expected state walk from the
    // instruction semantics, then checks every cycle's outputs against it.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int wf, input int wm);
        logic [3:0] tr[$];
        logic       rdy[$];
        logic       retire;
        logic [3:0] s;
        logic [5:0] e_str;
        logic [7:0] e_sel;
        logic [3:0] e_alu;
        logic       alu_known;
        retire = 1'b1;
        for (int i = 0; i < wf; i++) begin tr.push_back(4'd0); rdy.push_back(1'b0); end
        tr.push_back(4'd0); rdy.push_back(1'b1);
        tr.push_back(4'd1); rdy.push_back(1'b1);
        case (op)
            6'h00: begin
                tr.push_back(4'd6); rdy.push_back(1'b1);
                if (func_alu(fn) & 5'h10) begin tr.push_back(4'd7); rdy.push_back(1'b1); end
                else begin tr.push_back(4'd15); rdy.push_back(1'b1); retire = 1'b0; end
            end
            6'h23: begin
                tr.push_back(4'd2); rdy.push_back(1'b1);
                for (int i = 0; i < wm; i++) begin tr.push_back(4'd3); rdy.push_back(1'b0); end
                tr.push_back(4'd3); rdy.push_back(1'b1);
                tr.push_back(4'd4); rdy.push_back(1'b1);
            end
            6'h2B: begin
                tr.push_back(4'd2); rdy.push_back(1'b1);
                for (int i = 0; i < wm; i++) begin tr.push_back(4'd5); rdy.push_back(1'b0); end
                tr.push_back(4'd5); rdy.push_back(1'b1);
            end
            6'h04, 6'h05: begin tr.push_back(4'd8); rdy.push_back(1'b1); end
            6'h02: begin tr.push_back(4'd9); rdy.push_back(1'b1); end
            6'h08: begin
                tr.push_back(4'd10); rdy.push_back(1'b1);
                tr.push_back(4'd11); rdy.push_back(1'b1);
            end
            default: begin tr.push_back(4'd15); rdy.push_back(1'b1); retire = 1'b0; end
        endcase
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clock);
            Op = op; Func = fn; Z = z; mem_ready = rdy[i];
            #1;
            s = tr[i];
            vectors++;
            if (State !== s) begin
                errors++;
                $display("FAIL state op=%h step %0d: got %0d want %0d", op, i, State, s);
            end
            // {PCEn, IRWrite, MemRead, MemWrite, RegWrite, Halt}
            e_str = {(s == 4'd0 && rdy[i]) || s == 4'd9 || (s == 4'd8 && (op == 6'h04 ? z : !z)),
                     s == 4'd0 && rdy[i], s == 4'd0 || s == 4'd3, s == 4'd5,
                     s == 4'd7 || s == 4'd4 || s == 4'd11, s == 4'd15};
            vectors++;
            if ({PCEn, IRWrite, MemRead, MemWrite, RegWrite, Halt} !== e_str) begin
                errors++;
                $display("FAIL strobes op=%h state %0d: got %b want %b", op, s,
                         {PCEn, IRWrite, MemRead, MemWrite, RegWrite, Halt}, e_str);
            end
            // {IorD, RegDst, MemToReg, ALUSrcA, ALUSrcB, PCSource}
            e_sel = {s == 4'd3 || s == 4'd5, s == 4'd7, s == 4'd4,
                     s == 4'd2 || s == 4'd6 || s == 4'd8 || s == 4'd10,
                     (s == 4'd0) ? 2'd1 : (s == 4'd1) ? 2'd3 : (s == 4'd2 || s == 4'd10) ? 2'd2 : 2'd0,
                     (s == 4'd8) ? 2'd1 : (s == 4'd9) ? 2'd2 : 2'd0};
            vectors++;
            if ({IorD, RegDst, MemToReg, ALUSrcA, ALUSrcB, PCSource} !== e_sel) begin
                errors++;
                $display("FAIL selects op=%h state %0d: got %b want %b", op, s,
                         {IorD, RegDst, MemToReg, ALUSrcA, ALUSrcB, PCSource}, e_sel);
            end
            alu_known = 1'b1;
            if (s == 4'd0 || s == 4'd1 || s == 4'd2 || s == 4'd10) e_alu = 4'b0010;
            else if (s == 4'd8) e_alu = 4'b0110;
            else if (s == 4'd6) begin
                e_alu = func_alu(fn) & 5'h0F;
                alu_known = (func_alu(fn) & 5'h10) != 5'h0;
            end else e_alu = 4'b0000;
            if (alu_known) begin
                vectors++;
                if (ALUCntl !== e_alu) begin
                    errors++;
                    $display("FAIL alucntl op=%h fn=%h state %0d: got %b want %b", op, fn, s, ALUCntl, e_alu);
                end
            end
            vectors++;
            if (InstCount !== cnt_model) begin
                errors++;
                $display("FAIL instcount op=%h step %0d: got %h want %h", op, i, InstCount, cnt_model);
            end
        end
        if (retire) cnt_model = cnt_model + 32'd1;
    endtask

    task automatic test_reset();
        Op = 6'h00; Func = 6'h20; Z = 1'b0;
        @(negedge clock);
        Reset = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if ({PCEn, IRWrite, MemRead, MemWrite, RegWrite} !== 5'b0) begin
                errors++;
                $display("FAIL reset_strobes cyc %0d: got %b want 00000", i,
                         {PCEn, IRWrite, MemRead, MemWrite, RegWrite});
            end
            @(negedge clock);
        end
        #1;
        vectors++;
        if (State !== 4'd0 || InstCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d/%h want 0/0", State, InstCount);
        end
        mem_ready = 1'b0;
        Reset = 1'b1;
        cnt_model = 32'd0;
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (State !== 4'd0 || InstCount !== 32'd1) begin
            errors++;
            $display("FAIL rtype_retire: got %0d/%h want 0/1", State, InstCount);
        end
    endtask

    task automatic test_lw_wait();
        run_instr(6'h23, 6'h00, 1'b0, 0, 3);
        run_instr(6'h23, 6'h11, 1'b1, 2, 0);
    endtask

    task automatic test_instr_mix();
        logic [5:0] fns[6];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        for (int i = 0; i < 6; i++) run_instr(6'h00, fns[i], 1'b0, 0, 0);
        run_instr(6'h2B, 6'h00, 1'b0, 1, 2);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0);
        run_instr(6'h02, 6'h00, 1'b0, 0, 0);
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);
        run_instr(6'h05, 6'h00, 1'b0, 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[7];
        logic [5:0] fns[6];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 6)], fns[$urandom_range(0, 5)],
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)));
    endtask

    task automatic test_wrap();
        apply_reset();
        force dut.inst_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.inst_count_q;
        cnt_model = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) run_instr(6'h02, 6'h00, 1'b0, 0, 0);
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (InstCount !== 32'd1) begin
            errors++;
            $display("FAIL wrap: got %h want 00000001", InstCount);
        end
    endtask

    task automatic test_err();
        apply_reset();
        run_instr(6'h3F, 6'h20, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (State !== 4'd15 || Halt !== 1'b1 ||
                {PCEn, IRWrite, MemRead, MemWrite, RegWrite} !== 5'b0 || InstCount !== cnt_model) begin
                errors++;
                $display("FAIL err_hold cyc %0d: got st=%0d halt=%b str=%b cnt=%h want 15/1/00000/%h",
                         i, State, Halt, {PCEn, IRWrite, MemRead, MemWrite, RegWrite}, InstCount, cnt_model);
            end
        end
        @(negedge clock);
        Reset = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
        Reset = 1'b1;
        #1;
        vectors++;
        if (State !== 4'd0 || InstCount !== 32'd0 || Halt !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: got %0d/%h/%b want 0/0/0", State, InstCount, Halt);
        end
        cnt_model = 32'd0;
        // An unsupported funct traps as well.
        run_instr(6'h00, 6'h3F, 1'b0, 0, 0);
        apply_reset();
    endtask

    task automatic test_reset_in_memwr();
        run_instr(6'h02, 6'h00, 1'b0, 0, 0);
        Op = 6'h2B; Func = 6'h00;
        @(negedge clock); mem_ready = 1'b1;   // FETCH
        @(negedge clock);                      // DECODE
        @(negedge clock);                      // MEMADDR
        @(negedge clock); mem_ready = 1'b0;   // MEMWR, waiting
        #1;
        vectors++;
        if (State !== 4'd5 || MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL memwr_wait: got %0d/%b want 5/1", State, MemWrite);
        end
        @(negedge clock);
        Reset = 1'b0; mem_ready = 1'b1;
        #1;
        vectors++;
        if (MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL memwr_reset_gate: got %b want 0", MemWrite);
        end
        @(negedge clock);
        #1;
        vectors++;
        if (State !== 4'd0 || MemWrite !== 1'b0 || InstCount !== 32'd0) begin
            errors++;
            $display("FAIL memwr_reset: got %0d/%b/%h want 0/0/0", State, MemWrite, InstCount);
        end
        mem_ready = 1'b0;
        Reset = 1'b1;
        cnt_model = 32'd0;
    endtask

    initial begin
        Reset = 1'b0; Op = 6'h00; Func = 6'h00; Z = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_instr_mix();
        test_branch();
        test_back_to_back();
        test_wrap();
        test_err();
        test_reset_in_memwr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
